// File: rtl/ux607_tlarb_qspi.sv
// ---------------------------------------------------------------------------
// ux607_tlarb_qspi
// Two-requester TileLink-UL (A/D channels only) arbiter that shares the single
// 32-bit QSPI flash/register port between the instruction-fetch and data-bus
// masters. It sits in front of ux607_tlwidthwidget_qspi.
//
//   A channel : round-robin grant. The grant is held for every beat of a
//               multi-beat Put burst.
//   D channel : responses are steered back in issue order. A small ID FIFO
//               records which requester owns each outstanding request.
//   Both data paths are combinational pass-through. Only the control state
//   (lock, counters, pointer, FIFO) is registered.
//
// Ports
//   clock, reset                 sole clock, synchronous active-high reset
//   io_in_<n>_a_*   (n = 0,1)    requester A channel (valid/ready + bits)
//   io_in_<n>_d_*   (n = 0,1)    requester D channel (valid/ready + bits)
//   io_out_a_*                   shared A channel toward the width widget
//   io_out_d_*                   shared D channel from the width widget
//
// Configuration macro
//   UX607_QSPI_ARB_FIXPRIO_EN    when defined, req0 always wins a contended
//                                cycle and the round-robin pointer is removed
// ---------------------------------------------------------------------------
module ux607_tlarb_qspi #(
  parameter int DEPTH = 2,   // max outstanding requests, power of 2, >= 1
  parameter int MAXSZ = 5    // largest legal size (log2 bytes)
) (
  input  logic        clock,
  input  logic        reset,
  // requester 0
  input  logic        io_in_0_a_valid,
  output logic        io_in_0_a_ready,
  input  logic [2:0]  io_in_0_a_bits_opcode,
  input  logic [2:0]  io_in_0_a_bits_param,
  input  logic [2:0]  io_in_0_a_bits_size,
  input  logic [1:0]  io_in_0_a_bits_source,
  input  logic [29:0] io_in_0_a_bits_address,
  input  logic [3:0]  io_in_0_a_bits_mask,
  input  logic [31:0] io_in_0_a_bits_data,
  output logic        io_in_0_d_valid,
  input  logic        io_in_0_d_ready,
  output logic [2:0]  io_in_0_d_bits_opcode,
  output logic [1:0]  io_in_0_d_bits_param,
  output logic [2:0]  io_in_0_d_bits_size,
  output logic [1:0]  io_in_0_d_bits_source,
  output logic        io_in_0_d_bits_sink,
  output logic [1:0]  io_in_0_d_bits_addr_lo,
  output logic [31:0] io_in_0_d_bits_data,
  output logic        io_in_0_d_bits_error,
  // requester 1
  input  logic        io_in_1_a_valid,
  output logic        io_in_1_a_ready,
  input  logic [2:0]  io_in_1_a_bits_opcode,
  input  logic [2:0]  io_in_1_a_bits_param,
  input  logic [2:0]  io_in_1_a_bits_size,
  input  logic [1:0]  io_in_1_a_bits_source,
  input  logic [29:0] io_in_1_a_bits_address,
  input  logic [3:0]  io_in_1_a_bits_mask,
  input  logic [31:0] io_in_1_a_bits_data,
  output logic        io_in_1_d_valid,
  input  logic        io_in_1_d_ready,
  output logic [2:0]  io_in_1_d_bits_opcode,
  output logic [1:0]  io_in_1_d_bits_param,
  output logic [2:0]  io_in_1_d_bits_size,
  output logic [1:0]  io_in_1_d_bits_source,
  output logic        io_in_1_d_bits_sink,
  output logic [1:0]  io_in_1_d_bits_addr_lo,
  output logic [31:0] io_in_1_d_bits_data,
  output logic        io_in_1_d_bits_error,
  // shared port toward the width widget
  output logic        io_out_a_valid,
  input  logic        io_out_a_ready,
  output logic [2:0]  io_out_a_bits_opcode,
  output logic [2:0]  io_out_a_bits_param,
  output logic [2:0]  io_out_a_bits_size,
  output logic [1:0]  io_out_a_bits_source,
  output logic [29:0] io_out_a_bits_address,
  output logic [3:0]  io_out_a_bits_mask,
  output logic [31:0] io_out_a_bits_data,
  input  logic        io_out_d_valid,
  output logic        io_out_d_ready,
  input  logic [2:0]  io_out_d_bits_opcode,
  input  logic [1:0]  io_out_d_bits_param,
  input  logic [2:0]  io_out_d_bits_size,
  input  logic [1:0]  io_out_d_bits_source,
  input  logic        io_out_d_bits_sink,
  input  logic [1:0]  io_out_d_bits_addr_lo,
  input  logic [31:0] io_out_d_bits_data,
  input  logic        io_out_d_bits_error
);

  localparam int CW = (MAXSZ > 2) ? MAXSZ - 2 : 1;      // beat index width
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // FIFO pointer width
  localparam int NW = $clog2(DEPTH) + 1;                // FIFO occupancy width

  // Index of the last beat: 2^(size-2)-1 for multi-beat messages, else 0.
  function automatic logic [CW-1:0] last_idx(input logic multi, input logic [2:0] size);
    logic [7:0] n;
    n = 8'd0;
    if (multi && size > 3'd2) n = (8'd1 << (size - 3'd2)) - 8'd1;
    return n[CW-1:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic          lock_q, gnt_q;
  logic [CW-1:0] a_cnt_q, d_cnt_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q;
  logic          fifo_q [DEPTH];

  logic g, pick, vg, first_beat, fifo_full, fifo_empty, a_gate, a_fire, a_last;
  logic push, head, d_ok, d_fire, d_last, pop;

`ifdef UX607_QSPI_ARB_FIXPRIO_EN
  // req0 wins whenever both are valid.
  assign pick = ~io_in_0_a_valid & io_in_1_a_valid;
`else
  logic ptr_q;
  assign pick = (io_in_0_a_valid & io_in_1_a_valid) ? ptr_q : io_in_1_a_valid;
`endif

  always_comb begin
    // NOTE: every always_comb output is assigned first so no path leaves it
    // holding its old value; a missing default here would infer a latch.
    g          = lock_q ? gnt_q : pick;
    vg         = g ? io_in_1_a_valid : io_in_0_a_valid;
    first_beat = ~lock_q;
    fifo_full  = (count_q == NW'(DEPTH));
    fifo_empty = (count_q == '0);
    // A full FIFO only blocks the start of a new message, never a burst tail.
    a_gate     = ~reset & ~(first_beat & fifo_full);
    a_fire     = vg & a_gate & io_out_a_ready;
    a_last     = (a_cnt_q == last_idx(io_out_a_bits_opcode inside {3'd0, 3'd1},
                                      io_out_a_bits_size));
    push       = a_fire & first_beat;
    head       = fifo_q[rd_ptr_q];
    d_ok       = ~reset & ~fifo_empty;
    d_fire     = io_out_d_valid & io_out_d_ready;
    d_last     = (d_cnt_q == last_idx(io_out_d_bits_opcode == 3'd1, io_out_d_bits_size));
    pop        = d_fire & d_last;
  end

  // A channel: grant mux, valid/ready steering.
  assign io_out_a_valid        = vg & a_gate;
  assign io_in_0_a_ready       = a_gate & io_out_a_ready & ~g;
  assign io_in_1_a_ready       = a_gate & io_out_a_ready &  g;
  assign io_out_a_bits_opcode  = g ? io_in_1_a_bits_opcode  : io_in_0_a_bits_opcode;
  assign io_out_a_bits_param   = g ? io_in_1_a_bits_param   : io_in_0_a_bits_param;
  assign io_out_a_bits_size    = g ? io_in_1_a_bits_size    : io_in_0_a_bits_size;
  assign io_out_a_bits_source  = g ? io_in_1_a_bits_source  : io_in_0_a_bits_source;
  assign io_out_a_bits_address = g ? io_in_1_a_bits_address : io_in_0_a_bits_address;
  assign io_out_a_bits_mask    = g ? io_in_1_a_bits_mask    : io_in_0_a_bits_mask;
  assign io_out_a_bits_data    = g ? io_in_1_a_bits_data    : io_in_0_a_bits_data;

  // D channel: only valid/ready are steered by the FIFO head. A response
  // arriving with nothing outstanding is never accepted (ready stays low).
  assign io_in_0_d_valid = d_ok & io_out_d_valid & ~head;
  assign io_in_1_d_valid = d_ok & io_out_d_valid &  head;
  assign io_out_d_ready  = d_ok & (head ? io_in_1_d_ready : io_in_0_d_ready);

  assign io_in_0_d_bits_opcode  = io_out_d_bits_opcode;
  assign io_in_0_d_bits_param   = io_out_d_bits_param;
  assign io_in_0_d_bits_size    = io_out_d_bits_size;
  assign io_in_0_d_bits_source  = io_out_d_bits_source;
  assign io_in_0_d_bits_sink    = io_out_d_bits_sink;
  assign io_in_0_d_bits_addr_lo = io_out_d_bits_addr_lo;
  assign io_in_0_d_bits_data    = io_out_d_bits_data;
  assign io_in_0_d_bits_error   = io_out_d_bits_error;
  assign io_in_1_d_bits_opcode  = io_out_d_bits_opcode;
  assign io_in_1_d_bits_param   = io_out_d_bits_param;
  assign io_in_1_d_bits_size    = io_out_d_bits_size;
  assign io_in_1_d_bits_source  = io_out_d_bits_source;
  assign io_in_1_d_bits_sink    = io_out_d_bits_sink;
  assign io_in_1_d_bits_addr_lo = io_out_d_bits_addr_lo;
  assign io_in_1_d_bits_data    = io_out_d_bits_data;
  assign io_in_1_d_bits_error   = io_out_d_bits_error;

  // NOTE: registers are written with <= so every block samples the values
  // from before the edge; blocking = here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q   <= 1'b0;
      gnt_q    <= 1'b0;
      a_cnt_q  <= '0;
      d_cnt_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (a_fire) begin
        if (a_last) begin
          lock_q  <= 1'b0;
          a_cnt_q <= '0;
        end else begin
          lock_q  <= 1'b1;
          gnt_q   <= g;
          a_cnt_q <= a_cnt_q + 1'b1;
        end
      end
      if (d_fire) d_cnt_q <= d_last ? '0 : d_cnt_q + 1'b1;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef UX607_QSPI_ARB_FIXPRIO_EN
  // The finishing requester yields priority once its message is fully sent.
  always_ff @(posedge clock) begin
    if (reset)                ptr_q <= 1'b0;
    else if (a_fire && a_last) ptr_q <= ~g;
  end
`endif

  // NOTE: FIFO storage has no reset; an entry is only read while count_q
  // says it is valid, so clearing the pointers is enough.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= g;
  end

endmodule
